// File: rtl/ascon_rc_sequencer_if.sv
// ---------------------------------------------------------------------------
// ascon_rc_sequencer_if
// Handshake and lane bus between the permutation controller (master) and the
// round-constant sequencer (slave).
//   start_i / rounds_i : run request and round count (1..MAX_ROUNDS)
//   stall_i / abort_i  : datapath backpressure and run cancellation
//   x2_i / x2_o        : lane x2 in, lane x2 with constant applied out
//   rc_o, round_idx_o  : current constant and absolute round index
//   valid_o, last_o    : round beat and final-beat marker
//   busy_o, done_o     : run in progress, one-cycle completion pulse
//   err_o              : one-cycle pulse for an illegal round count
// ---------------------------------------------------------------------------
interface ascon_rc_sequencer_if #(
    parameter int LANE_W = 64
);
    logic              start_i;
    logic [3:0]        rounds_i;
    logic              stall_i;
    logic              abort_i;
    logic [LANE_W-1:0] x2_i;
    logic [LANE_W-1:0] x2_o;
    logic [7:0]        rc_o;
    logic [3:0]        round_idx_o;
    logic              valid_o;
    logic              last_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    modport master (
        output start_i, rounds_i, stall_i, abort_i, x2_i,
        input  x2_o, rc_o, round_idx_o, valid_o, last_o, busy_o, done_o, err_o
    );

    modport slave (
        input  start_i, rounds_i, stall_i, abort_i, x2_i,
        output x2_o, rc_o, round_idx_o, valid_o, last_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/ascon_rc_sequencer.sv
// ---------------------------------------------------------------------------
// ascon_rc_sequencer
// Sequential round-constant engine for the ASCON permutation. A run of R
// rounds walks the absolute round index from MAX_ROUNDS-R up to MAX_ROUNDS-1
// and XORs the constant {~idx, idx} into the low byte of lane x2.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of ascon_rc_sequencer_if (see interface header)
// ---------------------------------------------------------------------------
module ascon_rc_sequencer #(
    parameter int LANE_W     = 64,
    parameter int MAX_ROUNDS = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ascon_rc_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] MAX_R    = 4'(MAX_ROUNDS);
    localparam logic [3:0] LAST_IDX = 4'(MAX_ROUNDS - 1);

    state_t     state_reg, state_next;
    logic [3:0] idx_reg, idx_next;
    logic       err_reg, err_next;
    logic       valid_next;
    logic       last_next;
    logic [7:0] rc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= 4'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            err_reg   <= err_next;
        end
    end

    // Next-state and beat logic
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        err_next   = 1'b0;
        valid_next = 1'b0;
        last_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                // abort wins over a simultaneous start, and suppresses err
                if (bus.start_i && !bus.abort_i) begin
                    if ((bus.rounds_i != 4'd0) && (bus.rounds_i <= MAX_R)) begin
                        // p^b runs are the tail of the full schedule
                        idx_next   = MAX_R - bus.rounds_i;
                        state_next = RUN;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.abort_i) begin
                    state_next = IDLE;
                end else if (!bus.stall_i) begin
                    valid_next = 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        last_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        idx_next = idx_reg + 4'd1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The constant is only applied while a run is active; otherwise x2 passes
    // through untouched.
    assign rc = (state_reg == RUN) ? {~idx_reg, idx_reg} : 8'h00;

    for (genvar gi = 0; gi < LANE_W; gi++) begin : g_x2
        if (gi < 8) begin : g_rc_bit
            assign bus.x2_o[gi] = bus.x2_i[gi] ^ rc[gi];
        end else begin : g_pass_bit
            assign bus.x2_o[gi] = bus.x2_i[gi];
        end
    end

    assign bus.rc_o        = rc;
    assign bus.round_idx_o = idx_reg;
    assign bus.valid_o     = valid_next;
    assign bus.last_o      = last_next;
    assign bus.busy_o      = (state_reg == RUN);
    assign bus.done_o      = (state_reg == DONE);
    assign bus.err_o       = err_reg;

endmodule

// File: tb/tb_ascon_rc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ascon_rc_sequencer
// Directed stimulus for ascon_rc_sequencer. Expected beats ({last, rc}) are
// queued when a run is launched and popped by a negedge monitor whenever the
// DUT presents a valid beat.
// ---------------------------------------------------------------------------
module tb_ascon_rc_sequencer;
    localparam int LANE_W = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    ascon_rc_sequencer_if #(.LANE_W(LANE_W)) bus ();

    ascon_rc_sequencer #(.LANE_W(LANE_W), .MAX_ROUNDS(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;
    int done_snap;

    logic [8:0] exp_q[$];
    logic [8:0] mon_e;
    logic [7:0] rc_tab [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Beat monitor / scoreboard consumer
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done_o) done_seen++;
            if (bus.valid_o) begin
                check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("beat_rc", 64'(bus.rc_o), 64'(mon_e[7:0]));
                    check("beat_x2", bus.x2_o, bus.x2_i ^ {56'd0, mon_e[7:0]});
                    check("beat_last", 64'(bus.last_o), 64'(mon_e[8]));
                    $display("[TB] beat rc=%02h last=%0b idx=%0d", bus.rc_o, bus.last_o, bus.round_idx_o);
                end
            end else if (bus.last_o) begin
                check("last_without_beat", 64'(bus.last_o), 64'd0);
            end
        end
    end

    task automatic push_beats(input int first, input int n);
        for (int s = first; s < first + n; s++)
            exp_q.push_back({(s == 11), rc_tab[s]});
    endtask

    // Launch a run and drive it cycle by cycle. Cycle c=1 is the first cycle
    // in RUN. exp_done is the cycle in which done_o is expected (0 = never).
    task automatic run(input int r, input int stall_at, input int stall_len,
                       input logic [7:0] stall_rc, input int abort_at,
                       input int start_at, input int exp_done);
        int c;
        int done_c;
        bus.start_i  = 1'b1;
        bus.rounds_i = 4'(r);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        c = 1;
        done_c = 0;
        while (c <= 40 && done_c == 0) begin
            bus.stall_i = (c >= stall_at) && (c < stall_at + stall_len);
            bus.abort_i = (c == abort_at);
            if (c == start_at) begin
                bus.start_i  = 1'b1;
                bus.rounds_i = 4'd3;
            end else begin
                bus.start_i = 1'b0;
            end
            @(negedge clk);
            if (bus.stall_i && !bus.abort_i) begin
                check("stall_valid", 64'(bus.valid_o), 64'd0);
                check("stall_rc", 64'(bus.rc_o), 64'(stall_rc));
                check("stall_busy", 64'(bus.busy_o), 64'd1);
            end
            if (bus.abort_i)
                check("abort_valid", 64'(bus.valid_o), 64'd0);
            if (abort_at > 0 && c == abort_at + 1)
                check("abort_idle", 64'(bus.busy_o), 64'd0);
            if (bus.done_o) done_c = c;
            @(posedge clk); #1;
            c++;
            if (abort_at > 0 && c > abort_at + 3) break;
        end
        bus.stall_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.start_i = 1'b0;
        check("done_cycle", 64'(done_c), 64'(exp_done));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("busy_after_run", 64'(bus.busy_o), 64'd0);
        $display("[TB] run rounds=%0d stall_at=%0d abort_at=%0d done_cycle=%0d", r, stall_at, abort_at, done_c);
    endtask

    // One start in IDLE; err_o must pulse (or not) exactly once.
    task automatic err_case(input int r, input logic ab, input logic exp_err);
        bus.start_i  = 1'b1;
        bus.abort_i  = ab;
        bus.rounds_i = 4'(r);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        @(negedge clk);
        check("err_pulse", 64'(bus.err_o), 64'(exp_err));
        check("err_busy", 64'(bus.busy_o), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("err_clear", 64'(bus.err_o), 64'd0);
        check("err_busy2", 64'(bus.busy_o), 64'd0);
        @(posedge clk); #1;
        $display("[TB] start rounds=%0d abort=%0b err=%0b", r, ab, exp_err);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_i  = 1'b0;
        bus.rounds_i = 4'd0;
        bus.stall_i  = 1'b0;
        bus.abort_i  = 1'b0;
        bus.x2_i     = 64'h0123_4567_89AB_CDEF;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_valid", 64'(bus.valid_o), 64'd0);
        check("rst_last", 64'(bus.last_o), 64'd0);
        check("rst_done", 64'(bus.done_o), 64'd0);
        check("rst_err", 64'(bus.err_o), 64'd0);
        check("rst_rc", 64'(bus.rc_o), 64'd0);
        check("rst_idx", 64'(bus.round_idx_o), 64'd0);
        check("rst_x2", bus.x2_o, 64'h0123_4567_89AB_CDEF);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_x2_pass", bus.x2_o, bus.x2_i);

        // Full 12-round run with a start issued mid-run (must be ignored)
        bus.x2_i = {$urandom, $urandom};
        push_beats(0, 12);
        run(12, 0, 0, 8'h00, 0, 4, 13);
        repeat (3) begin
            @(negedge clk);
            check("ignored_start_idle", 64'(bus.busy_o), 64'd0);
            @(posedge clk); #1;
        end

        // p^b style runs, x2 zero
        bus.x2_i = 64'd0;
        push_beats(6, 6);
        run(6, 0, 0, 8'h00, 0, 0, 7);
        push_beats(4, 8);
        run(8, 0, 0, 8'h00, 0, 0, 9);

        // Stall on beats 3 and 4 of an 8-round run: constant held at beat 3
        bus.x2_i = {$urandom, $urandom};
        push_beats(4, 8);
        run(8, 3, 2, rc_tab[6], 0, 0, 11);

        // Illegal round counts, then abort overriding start in IDLE
        err_case(0, 1'b0, 1'b1);
        err_case(13, 1'b0, 1'b1);
        err_case(0, 1'b1, 1'b0);
        err_case(5, 1'b1, 1'b0);

        // Single-round run
        push_beats(11, 1);
        run(1, 0, 0, 8'h00, 0, 0, 2);

        // Abort on beat 5 of a 12-round run, then a clean restart
        done_snap = done_seen;
        push_beats(0, 4);
        run(12, 0, 0, 8'h00, 5, 0, 0);
        check("abort_no_done", 64'(done_seen), 64'(done_snap));
        push_beats(0, 12);
        run(12, 0, 0, 8'h00, 0, 0, 13);

        // Asynchronous reset mid-run
        done_snap = done_seen;
        push_beats(0, 12);
        bus.start_i  = 1'b1;
        bus.rounds_i = 4'd12;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy_o), 64'd0);
        check("arst_valid", 64'(bus.valid_o), 64'd0);
        check("arst_last", 64'(bus.last_o), 64'd0);
        check("arst_done", 64'(bus.done_o), 64'd0);
        check("arst_err", 64'(bus.err_o), 64'd0);
        check("arst_rc", 64'(bus.rc_o), 64'd0);
        check("arst_idx", 64'(bus.round_idx_o), 64'd0);
        check("arst_x2", bus.x2_o, bus.x2_i);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_busy", 64'(bus.busy_o), 64'd0);
            check("post_rst_valid", 64'(bus.valid_o), 64'd0);
        end
        check("arst_no_done", 64'(done_seen), 64'(done_snap));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
